game_flow_ctrl: RTL and testbench

// Parametrised game-flow sequencer for the top-level game; drives game_status/world/level/lives.

---
 rtl/game_flow_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: START -> PLAYING -> banner holds -> LOSE/WIN, tracking world, level, lives and bonus streak.
// Registered outputs; state and counters change on the same edge; inputs sampled every cycle, no backpressure.
module game_flow_ctrl #(
   parameter int NUM_WORLDS       = 4,
   parameter int LEVELS_PER_WORLD = 6,
   parameter int START_LIVES      = 3,
   parameter int MAX_LIVES        = 9,
   parameter int BONUS_EVERY      = 3,
   parameter int BANNER_CYCLES    = 50000000,
   parameter int WORLD_W          = 2,
   parameter int LEVEL_W          = 3,
   parameter int LIVES_W          = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic [1:0]         player_status,
   output logic [2:0]         game_status,
   output logic [WORLD_W-1:0] world,
   output logic [LEVEL_W-1:0] level,
   output logic [LIVES_W-1:0] lives,
   output logic               status_strobe
);

   localparam int HOLD_W   = (BANNER_CYCLES > 1) ? $clog2(BANNER_CYCLES) : 1;
   localparam int STREAK_W = $clog2(BONUS_EVERY + 1);

   localparam logic [WORLD_W-1:0]  LAST_WORLD   = WORLD_W'(NUM_WORLDS - 1);
   localparam logic [LEVEL_W-1:0]  LAST_LEVEL   = LEVEL_W'(LEVELS_PER_WORLD - 1);
   localparam logic [LIVES_W-1:0]  LIVES_START  = LIVES_W'(START_LIVES);
   localparam logic [LIVES_W-1:0]  LIVES_MAX    = LIVES_W'(MAX_LIVES);
   localparam logic [LIVES_W-1:0]  LIVES_ONE    = LIVES_W'(1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST    = HOLD_W'(BANNER_CYCLES - 1);
   localparam logic [STREAK_W-1:0] STREAK_BONUS = STREAK_W'(BONUS_EVERY);

   localparam logic [1:0] PS_PLAY = 2'd0;
   localparam logic [1:0] PS_PASS = 2'd1;
   localparam logic [1:0] PS_DIED = 2'd2;
   localparam logic [1:0] PS_RSVD = 2'd3;

   typedef enum logic [2:0] {
      S_START     = 3'd0,
      S_PLAYING   = 3'd1,
      S_LEVEL_INC = 3'd2,
      S_WORLD_INC = 3'd3,
      S_LIVES_INC = 3'd4,
      S_LOSE      = 3'd5,
      S_WIN       = 3'd6,
      S_DIED      = 3'd7
   } state_e;

   state_e              state_q,    state_d;
   logic [WORLD_W-1:0]  world_q,    world_d;
   logic [LEVEL_W-1:0]  level_q,    level_d;
   logic [LIVES_W-1:0]  lives_q,    lives_d;
   logic [STREAK_W-1:0] streak_q,   streak_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                armed_q,    armed_d;
   logic                start_q,    start_d;
   logic                strobe_q,   strobe_d;
   logic                start_edge;
   logic                hold_done;

   assign start_edge = start_btn & ~start_q;
   assign hold_done  = (hold_cnt_q == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_START;
         world_q    <= '0;
         level_q    <= '0;
         lives_q    <= LIVES_START;
         streak_q   <= '0;
         hold_cnt_q <= '0;
         armed_q    <= 1'b0;
         start_q    <= 1'b1;
         strobe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         world_q    <= world_d;
         level_q    <= level_d;
         lives_q    <= lives_d;
         streak_q   <= streak_d;
         hold_cnt_q <= hold_cnt_d;
         armed_q    <= armed_d;
         start_q    <= start_d;
         strobe_q   <= strobe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      world_d    = world_q;
      level_d    = level_q;
      lives_d    = lives_q;
      streak_d   = streak_q;
      hold_cnt_d = '0;
      case (state_q)
         S_START: begin
            if (start_edge) state_d = S_PLAYING;
         end
         S_PLAYING: begin
            if (armed_q && player_status == PS_PASS) begin
               if (level_q == LAST_LEVEL && world_q == LAST_WORLD) begin
                  state_d = S_WIN;
               end else if (level_q == LAST_LEVEL) begin
                  state_d  = S_WORLD_INC;
                  world_d  = world_q + 1'b1;
                  level_d  = '0;
                  streak_d = streak_q + 1'b1;
               end else begin
                  state_d  = S_LEVEL_INC;
                  level_d  = level_q + 1'b1;
                  streak_d = streak_q + 1'b1;
               end
            end else if (armed_q && player_status == PS_DIED) begin
               if (lives_q == LIVES_ONE) begin
                  state_d = S_LOSE;
                  lives_d = '0;
               end else begin
                  state_d  = S_DIED;
                  lives_d  = lives_q - 1'b1;
                  streak_d = '0;
               end
            end
         end
         S_LEVEL_INC, S_WORLD_INC: begin
            if (!hold_done) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end else if (streak_q == STREAK_BONUS) begin
               // Streak is consumed even when the bonus life is forfeited at the cap.
               streak_d = '0;
               if (lives_q < LIVES_MAX) begin
                  state_d = S_LIVES_INC;
                  lives_d = lives_q + 1'b1;
               end else begin
                  state_d = S_PLAYING;
               end
            end else begin
               state_d = S_PLAYING;
            end
         end
         S_LIVES_INC, S_DIED: begin
            if (hold_done) state_d = S_PLAYING;
            else           hold_cnt_d = hold_cnt_q + 1'b1;
         end
         S_LOSE, S_WIN: begin
            if (start_edge) begin
               state_d  = S_START;
               world_d  = '0;
               level_d  = '0;
               lives_d  = LIVES_START;
               streak_d = '0;
            end
         end
         default: state_d = S_START;
      endcase
      // Arming needs a playing/reserved code seen while already in PLAYING, so a held pass cannot re-trigger.
      armed_d  = (state_q == S_PLAYING) && (state_d == S_PLAYING) &&
                 (armed_q || player_status == PS_PLAY || player_status == PS_RSVD);
      start_d  = start_btn;
      strobe_d = (state_d != state_q);
   end

   always_comb begin
      game_status   = state_q;
      world         = world_q;
      level         = level_q;
      lives         = lives_q;
      status_strobe = strobe_q;
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: scripted vector table, bonus-cap sequence, then random play against a reference model.
module tb_game_flow_ctrl;

   localparam int NW = 2, LPW = 2, SL = 2, ML = 3, BE = 2, BC = 4;
   localparam int SL_CAP = 3;
   localparam int ST_START = 0, ST_PLAY = 1, ST_LEVEL = 2, ST_WORLD = 3;
   localparam int ST_LIVES = 4, ST_LOSE = 5, ST_WIN = 6, ST_DIED = 7;

   logic       clk;
   logic       rst;
   logic       start_btn;
   logic [1:0] ps;
   logic [2:0] st0, st1;
   logic [1:0] w0, w1;
   logic [2:0] l0, l1;
   logic [3:0] lv0, lv1;
   logic       sb0, sb1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   game_flow_ctrl #(.NUM_WORLDS(NW), .LEVELS_PER_WORLD(LPW), .START_LIVES(SL), .MAX_LIVES(ML),
                    .BONUS_EVERY(BE), .BANNER_CYCLES(BC), .WORLD_W(2), .LEVEL_W(3), .LIVES_W(4))
   u_dut (.clk(clk), .rst(rst), .start_btn(start_btn), .player_status(ps), .game_status(st0),
          .world(w0), .level(l0), .lives(lv0), .status_strobe(sb0));

   game_flow_ctrl #(.NUM_WORLDS(NW), .LEVELS_PER_WORLD(LPW), .START_LIVES(SL_CAP), .MAX_LIVES(ML),
                    .BONUS_EVERY(BE), .BANNER_CYCLES(BC), .WORLD_W(2), .LEVEL_W(3), .LIVES_W(4))
   u_cap (.clk(clk), .rst(rst), .start_btn(start_btn), .player_status(ps), .game_status(st1),
          .world(w1), .level(l1), .lives(lv1), .status_strobe(sb1));

   typedef struct {
      bit       r;
      bit       b;
      bit [1:0] p;
      int       n;
      int       st;
      int       w;
      int       l;
      int       lv;
      bit       sb;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: progress kept as a linear level index, holds as a countdown.
   int m_st[2], m_prog[2], m_lives[2], m_streak[2], m_hold[2];
   bit m_armed[2], m_prev[2], m_sb[2];

   function automatic logic [12:0] pack(input int st, input int w, input int l, input int lv, input bit sb);
      return {3'(st), 2'(w), 3'(l), 4'(lv), sb};
   endfunction

   function automatic logic [12:0] obs0();
      return {st0, w0, l0, lv0, sb0};
   endfunction

   function automatic logic [12:0] obs1();
      return {st1, w1, l1, lv1, sb1};
   endfunction

   function automatic logic [12:0] model_obs(input int k);
      return pack(m_st[k], m_prog[k] / LPW, m_prog[k] % LPW, m_lives[k], m_sb[k]);
   endfunction

   task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got {st,w,l,lives,strobe}=%h required %h", name, got, exp);
   endtask

   task automatic add(input bit r, input bit b, input bit [1:0] p, input int n,
                      input int st, input int w, input int l, input int lv, input bit sb);
      vec_t v;
      v.r = r; v.b = b; v.p = p; v.n = n; v.st = st; v.w = w; v.l = l; v.lv = lv; v.sb = sb;
      tbl.push_back(v);
   endtask

   task automatic cyc(input bit r, input bit b, input bit [1:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = r; start_btn = b; ps = p;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_step(input int k, input bit r, input bit b, input bit [1:0] p);
      int old;
      bit edge_seen;
      int start_lv;
      start_lv = (k == 0) ? SL : SL_CAP;
      if (r) begin
         m_st[k] = ST_START; m_prog[k] = 0; m_lives[k] = start_lv; m_streak[k] = 0;
         m_hold[k] = 0; m_armed[k] = 0; m_prev[k] = 1; m_sb[k] = 0;
         return;
      end
      edge_seen = b && !m_prev[k];
      m_prev[k] = b;
      old = m_st[k];
      case (m_st[k])
         ST_START: if (edge_seen) m_st[k] = ST_PLAY;
         ST_PLAY: begin
            if (!m_armed[k]) begin
               m_armed[k] = (p == 0 || p == 3);
            end else if (p == 1) begin
               m_armed[k] = 0;
               if (m_prog[k] == NW * LPW - 1) begin
                  m_st[k] = ST_WIN;
               end else begin
                  m_prog[k]++;
                  m_streak[k]++;
                  m_st[k]   = (m_prog[k] % LPW == 0) ? ST_WORLD : ST_LEVEL;
                  m_hold[k] = BC;
               end
            end else if (p == 2) begin
               m_armed[k] = 0;
               if (m_lives[k] == 1) begin
                  m_lives[k] = 0;
                  m_st[k]    = ST_LOSE;
               end else begin
                  m_lives[k]--;
                  m_streak[k] = 0;
                  m_st[k]     = ST_DIED;
                  m_hold[k]   = BC;
               end
            end
         end
         ST_LEVEL, ST_WORLD, ST_LIVES, ST_DIED: begin
            m_hold[k]--;
            if (m_hold[k] == 0) begin
               if ((m_st[k] == ST_LEVEL || m_st[k] == ST_WORLD) && m_streak[k] == BE) begin
                  m_streak[k] = 0;
                  if (m_lives[k] < ML) begin
                     m_lives[k]++;
                     m_st[k]   = ST_LIVES;
                     m_hold[k] = BC;
                  end else begin
                     m_st[k] = ST_PLAY;
                  end
               end else begin
                  m_st[k] = ST_PLAY;
               end
            end
         end
         default: begin
            if (edge_seen) begin
               m_st[k] = ST_START; m_prog[k] = 0; m_lives[k] = start_lv; m_streak[k] = 0;
            end
         end
      endcase
      m_sb[k] = (m_st[k] != old);
   endtask

   initial begin
      bit       rb;
      bit       rr;
      bit [1:0] rp;
      int       x;

      rst = 1'b1; start_btn = 1'b1; ps = 2'd0;

      //   r  b  p  n  status    w  l  lives strobe
      add(1, 1, 0, 2, ST_START, 0, 0, 2, 0);
      add(0, 1, 0, 3, ST_START, 0, 0, 2, 0);
      add(0, 0, 0, 2, ST_START, 0, 0, 2, 0);
      add(0, 1, 0, 1, ST_PLAY,  0, 0, 2, 1);
      add(0, 1, 0, 1, ST_PLAY,  0, 0, 2, 0);
      add(0, 0, 1, 1, ST_LEVEL, 0, 1, 2, 1);
      add(0, 0, 1, 3, ST_LEVEL, 0, 1, 2, 0);
      add(0, 0, 1, 1, ST_PLAY,  0, 1, 2, 1);
      add(0, 0, 1, 3, ST_PLAY,  0, 1, 2, 0);
      add(0, 0, 0, 1, ST_PLAY,  0, 1, 2, 0);
      add(0, 0, 1, 1, ST_WORLD, 1, 0, 2, 1);
      add(0, 0, 0, 3, ST_WORLD, 1, 0, 2, 0);
      add(0, 0, 0, 1, ST_LIVES, 1, 0, 3, 1);
      add(0, 0, 0, 3, ST_LIVES, 1, 0, 3, 0);
      add(0, 0, 0, 1, ST_PLAY,  1, 0, 3, 1);
      add(0, 0, 0, 1, ST_PLAY,  1, 0, 3, 0);
      add(0, 0, 2, 1, ST_DIED,  1, 0, 2, 1);
      add(0, 0, 2, 3, ST_DIED,  1, 0, 2, 0);
      add(0, 0, 2, 1, ST_PLAY,  1, 0, 2, 1);
      add(0, 0, 3, 1, ST_PLAY,  1, 0, 2, 0);
      add(0, 0, 2, 1, ST_DIED,  1, 0, 1, 1);
      add(0, 0, 0, 4, ST_PLAY,  1, 0, 1, 1);
      add(0, 0, 0, 1, ST_PLAY,  1, 0, 1, 0);
      add(0, 0, 2, 1, ST_LOSE,  1, 0, 0, 1);
      add(0, 0, 1, 3, ST_LOSE,  1, 0, 0, 0);
      add(0, 1, 0, 1, ST_START, 0, 0, 2, 1);
      add(0, 1, 0, 2, ST_START, 0, 0, 2, 0);
      add(0, 0, 0, 1, ST_START, 0, 0, 2, 0);
      add(0, 1, 0, 1, ST_PLAY,  0, 0, 2, 1);
      add(0, 0, 0, 1, ST_PLAY,  0, 0, 2, 0);
      add(0, 0, 1, 1, ST_LEVEL, 0, 1, 2, 1);
      add(0, 0, 0, 4, ST_PLAY,  0, 1, 2, 1);
      add(0, 0, 0, 1, ST_PLAY,  0, 1, 2, 0);
      add(0, 0, 1, 1, ST_WORLD, 1, 0, 2, 1);
      add(0, 0, 0, 4, ST_LIVES, 1, 0, 3, 1);
      add(0, 0, 0, 4, ST_PLAY,  1, 0, 3, 1);
      add(0, 0, 0, 1, ST_PLAY,  1, 0, 3, 0);
      add(0, 0, 1, 1, ST_LEVEL, 1, 1, 3, 1);
      add(0, 0, 0, 4, ST_PLAY,  1, 1, 3, 1);
      add(0, 0, 0, 1, ST_PLAY,  1, 1, 3, 0);
      add(0, 0, 1, 1, ST_WIN,   1, 1, 3, 1);
      add(0, 0, 2, 3, ST_WIN,   1, 1, 3, 0);
      add(0, 1, 0, 1, ST_START, 0, 0, 2, 1);
      add(0, 0, 0, 1, ST_START, 0, 0, 2, 0);
      add(0, 1, 0, 1, ST_PLAY,  0, 0, 2, 1);
      add(0, 0, 0, 1, ST_PLAY,  0, 0, 2, 0);
      add(0, 0, 1, 1, ST_LEVEL, 0, 1, 2, 1);
      add(0, 0, 0, 2, ST_LEVEL, 0, 1, 2, 0);
      add(1, 0, 0, 1, ST_START, 0, 0, 2, 0);
      add(0, 0, 0, 1, ST_START, 0, 0, 2, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].b, tbl[i].p, tbl[i].n);
         chk($sformatf("vec%0d", i), obs0(),
             pack(tbl[i].st, tbl[i].w, tbl[i].l, tbl[i].lv, tbl[i].sb));
      end

      // Bonus at the lives cap: u_cap starts at MAX_LIVES, u_dut starts below it.
      cyc(0, 1, 0, 1);
      chk("cap_start", obs1(), pack(ST_PLAY, 0, 0, 3, 1));
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
      chk("cap_level", obs1(), pack(ST_LEVEL, 0, 1, 3, 1));
      cyc(0, 0, 0, 4);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
      chk("cap_world", obs1(), pack(ST_WORLD, 1, 0, 3, 1));
      cyc(0, 0, 0, 3);
      cyc(0, 0, 0, 1);
      chk("cap_forfeit", obs1(), pack(ST_PLAY, 1, 0, 3, 1));
      chk("dut_bonus", obs0(), pack(ST_LIVES, 1, 0, 3, 1));
      cyc(0, 0, 0, 1);
      chk("cap_stay", obs1(), pack(ST_PLAY, 1, 0, 3, 0));

      rb = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rr = (c == 0) || ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) rb = ~rb;
         x  = $urandom_range(0, 19);
         rp = (x < 10) ? 2'd0 : (x < 15) ? 2'd1 : (x < 18) ? 2'd2 : 2'd3;
         rst = rr; start_btn = rb; ps = rp;
         @(posedge clk);
         model_step(0, rr, rb, rp);
         model_step(1, rr, rb, rp);
         #1;
         chk($sformatf("rand_dut c%0d", c), obs0(), model_obs(0));
         chk($sformatf("rand_cap c%0d", c), obs1(), model_obs(1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
